// File: rtl/argmax_classifier.sv
// argmax_classifier: captures a signed score vector and scans it
// one element per clock for the index of the largest score.
module argmax_classifier #(
  parameter int DATA_WIDTH  = 32,
  parameter int NUM_CLASSES = 10,
  parameter int INDEX_WIDTH = $clog2(NUM_CLASSES),
  parameter logic signed [DATA_WIDTH-1:0] THRESHOLD = '0
) (
  input  logic                         clock,
  input  logic                         reset,
  input  logic                         scores_ready,
  input  logic signed [DATA_WIDTH-1:0] scores [NUM_CLASSES],
  input  logic                         class_ack,
  output logic                         class_valid,
  output logic [INDEX_WIDTH-1:0]       class_index,
  output logic signed [DATA_WIDTH-1:0] class_score,
  output logic                         low_confidence,
  output logic                         busy,
  output logic                         overrun
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] SCAN = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  localparam logic [INDEX_WIDTH-1:0] LAST =
    INDEX_WIDTH'(NUM_CLASSES - 1);

  logic [1:0] state;
  logic signed [DATA_WIDTH-1:0] score_buf [NUM_CLASSES];
  logic signed [DATA_WIDTH-1:0] best_val;
  logic signed [DATA_WIDTH-1:0] next_val;
  logic [INDEX_WIDTH-1:0] best_idx;
  logic [INDEX_WIDTH-1:0] next_idx;
  logic [INDEX_WIDTH-1:0] idx;
  logic capture;

  assign busy = (state == SCAN);

  // A new vector is taken from IDLE, or from DONE when the ack
  // retires the held result in the same cycle.
  assign capture = scores_ready &&
    ((state == IDLE) || ((state == DONE) && class_ack));

  // Running best after this cycle's compare; strict > keeps
  // the lowest index on ties.
  always_comb begin
    next_val = best_val;
    next_idx = best_idx;
    if (score_buf[idx] > best_val) begin
      next_val = score_buf[idx];
      next_idx = idx;
    end
  end

  // Control FSM, score buffer and result registers.
  always_ff @(posedge clock) begin
    if (reset) begin
      state          <= IDLE;
      class_valid    <= 1'b0;
      class_index    <= '0;
      class_score    <= '0;
      low_confidence <= 1'b0;
      overrun        <= 1'b0;
      best_val       <= '0;
      best_idx       <= '0;
      idx            <= '0;
      for (int i = 0; i < NUM_CLASSES; i++)
        score_buf[i] <= '0;
    end else begin
      if (scores_ready && !capture)
        overrun <= 1'b1;
      if (capture) begin
        for (int i = 0; i < NUM_CLASSES; i++)
          score_buf[i] <= scores[i];
        best_val    <= scores[0];
        best_idx    <= '0;
        idx         <= INDEX_WIDTH'(1);
        class_valid <= 1'b0;
        state       <= SCAN;
      end else begin
        unique case (state)
          IDLE: ;
          SCAN: begin
            best_val <= next_val;
            best_idx <= next_idx;
            idx      <= idx + 1'b1;
            if (idx == LAST) begin
              class_index    <= next_idx;
              class_score    <= next_val;
              low_confidence <= (next_val < THRESHOLD);
              class_valid    <= 1'b1;
              state          <= DONE;
            end
          end
          DONE: begin
            if (class_ack) begin
              class_valid <= 1'b0;
              state       <= IDLE;
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule
